// File: rtl/codec_serializer_if.sv
// Producer/DAC-side signal bundle of the left-justified sample serializer.
// The master drives samples and enable; the slave (the serializer) drives the serial frame and status pulses.
interface codec_serializer_if #(
    parameter int SAMPLE_WIDTH = 16
) ();
    logic                           enable;
    logic signed [SAMPLE_WIDTH-1:0] sample_in;
    logic                           in_ready;
    logic                           bclk;
    logic                           lrclk;
    logic                           sdata;
    logic                           sample_req;
    logic                           underrun;
    logic                           overrun;

    modport master (
        output enable, sample_in, in_ready,
        input  bclk, lrclk, sdata, sample_req, underrun, overrun
    );

    modport slave (
        input  enable, sample_in, in_ready,
        output bclk, lrclk, sdata, sample_req, underrun, overrun
    );
endinterface

// File: rtl/codec_serializer.sv
// Mono sample serializer: one-sample hold buffer feeding a left-justified bclk/lrclk/sdata frame,
// with every sample sent in both slots and consume/underrun/overrun status pulses.
module codec_serializer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int BCLK_DIV     = 4
) (
    input  logic              clk,
    input  logic              reset,
    codec_serializer_if.slave bus
);
    localparam int FRAME_W = 2 * SAMPLE_WIDTH;
    localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [DIV_W-1:0]        div_cnt_r, div_cnt_nxt_s;
    logic [BIT_W-1:0]        bit_cnt_r, bit_cnt_nxt_s;
    logic                    bclk_r, bclk_nxt_s;
    logic [FRAME_W-1:0]      shreg_r, shreg_nxt_s;
    logic [SAMPLE_WIDTH-1:0] hold_r, hold_nxt_s;
    logic [SAMPLE_WIDTH-1:0] last_r, last_nxt_s;
    logic                    hold_valid_r, hold_valid_nxt_s;
    logic                    sample_req_r, sample_req_nxt_s;
    logic                    underrun_r, underrun_nxt_s;
    logic                    overrun_r, overrun_nxt_s;
    logic                    load_s;

    // Next-state logic: frame timing, frame loads and the hold buffer.
    always_comb begin
        state_nxt_s      = state_r;
        div_cnt_nxt_s    = div_cnt_r;
        bit_cnt_nxt_s    = bit_cnt_r;
        bclk_nxt_s       = bclk_r;
        shreg_nxt_s      = shreg_r;
        hold_nxt_s       = hold_r;
        last_nxt_s       = last_r;
        hold_valid_nxt_s = hold_valid_r;
        sample_req_nxt_s = 1'b0;
        underrun_nxt_s   = 1'b0;
        overrun_nxt_s    = 1'b0;
        load_s           = 1'b0;

        case (state_r)
            IDLE: begin
                div_cnt_nxt_s = '0;
                bit_cnt_nxt_s = '0;
                bclk_nxt_s    = 1'b0;
                shreg_nxt_s   = '0;
                if (bus.enable && hold_valid_r) begin
                    state_nxt_s = RUN;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (div_cnt_r == DIV_LAST) begin
                    div_cnt_nxt_s = '0;
                    bclk_nxt_s    = ~bclk_r;
                    // A wrap while bclk is high is the falling edge that advances the frame.
                    if (bclk_r) begin
                        if (bit_cnt_r == BIT_LAST) begin
                            bit_cnt_nxt_s = '0;
                            if (bus.enable) begin
                                load_s = 1'b1;
                            end else begin
                                state_nxt_s = IDLE;
                                shreg_nxt_s = '0;
                            end
                        end else begin
                            bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1);
                            shreg_nxt_s   = shreg_r << 1;
                        end
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r;
                    end
                end else begin
                    div_cnt_nxt_s = div_cnt_r + DIV_W'(1);
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                div_cnt_nxt_s = '0;
                bit_cnt_nxt_s = '0;
                bclk_nxt_s    = 1'b0;
                shreg_nxt_s   = '0;
            end
        endcase

        if (load_s) begin
            if (hold_valid_r) begin
                shreg_nxt_s      = {hold_r, hold_r};
                last_nxt_s       = hold_r;
                hold_valid_nxt_s = 1'b0;
                sample_req_nxt_s = 1'b1;
            end else begin
                shreg_nxt_s    = {last_r, last_r};
                underrun_nxt_s = 1'b1;
            end
        end else begin
            sample_req_nxt_s = 1'b0;
        end

        // A new sample always lands in hold; the load above has already taken the old one.
        if (bus.in_ready) begin
            hold_nxt_s       = bus.sample_in;
            hold_valid_nxt_s = 1'b1;
            overrun_nxt_s    = hold_valid_r & ~load_s;
        end else begin
            overrun_nxt_s = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            div_cnt_r    <= '0;
            bit_cnt_r    <= '0;
            bclk_r       <= 1'b0;
            shreg_r      <= '0;
            hold_r       <= '0;
            last_r       <= '0;
            hold_valid_r <= 1'b0;
            sample_req_r <= 1'b0;
            underrun_r   <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            div_cnt_r    <= div_cnt_nxt_s;
            bit_cnt_r    <= bit_cnt_nxt_s;
            bclk_r       <= bclk_nxt_s;
            shreg_r      <= shreg_nxt_s;
            hold_r       <= hold_nxt_s;
            last_r       <= last_nxt_s;
            hold_valid_r <= hold_valid_nxt_s;
            sample_req_r <= sample_req_nxt_s;
            underrun_r   <= underrun_nxt_s;
            overrun_r    <= overrun_nxt_s;
        end
    end

    assign bus.bclk       = bclk_r;
    assign bus.lrclk      = bit_cnt_r[BIT_W-1];
    assign bus.sdata      = shreg_r[FRAME_W-1];
    assign bus.sample_req = sample_req_r;
    assign bus.underrun   = underrun_r;
    assign bus.overrun    = overrun_r;
endmodule

// File: tb/tb_codec_serializer.sv
// Bench for codec_serializer: directed frame scenarios pinned with literal values, then random traffic,
// all compared every cycle against a frame-timer model of the serial output.
module tb_codec_serializer;
    localparam int SW    = 16;
    localparam int B     = 4;
    localparam int FRAME = 4 * SW * B;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    codec_serializer_if #(.SAMPLE_WIDTH(SW)) bus ();

    codec_serializer #(.SAMPLE_WIDTH(SW), .BCLK_DIV(B)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: position within the frame as a plain cycle count since the load.
    bit              m_run = 1'b0;
    int              m_t   = 0;
    logic [2*SW-1:0] m_word = '0;
    logic [SW-1:0]   m_hold = '0;
    logic [SW-1:0]   m_last = '0;
    bit              m_hv = 1'b0;
    bit              m_req = 1'b0;
    bit              m_und = 1'b0;
    bit              m_ovr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit load;
        bit hv0;
        if (!reset) begin
            m_run = 0; m_t = 0; m_word = '0; m_hold = '0; m_last = '0;
            m_hv = 0; m_req = 0; m_und = 0; m_ovr = 0;
        end else begin
            load = 0; hv0 = m_hv;
            m_req = 0; m_und = 0; m_ovr = 0;
            if (!m_run) begin
                if (bus.enable && m_hv) begin
                    m_run = 1; m_t = 0; load = 1;
                end
            end else begin
                m_t++;
                if (m_t == FRAME) begin
                    m_t = 0;
                    if (bus.enable) load = 1;
                    else m_run = 0;
                end
            end
            if (load) begin
                if (m_hv) begin
                    m_word = {m_hold, m_hold}; m_last = m_hold; m_hv = 0; m_req = 1;
                end else begin
                    m_word = {m_last, m_last}; m_und = 1;
                end
            end
            if (bus.in_ready) begin
                m_ovr  = hv0 && !load;
                m_hold = bus.sample_in;
                m_hv   = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    int   c_bit;
    logic e_bclk, e_lr, e_sd;

    // Cycle-by-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            c_bit  = m_t / (2 * B);
            e_bclk = m_run && (((m_t / B) % 2) == 1);
            e_lr   = m_run && (c_bit >= SW);
            e_sd   = m_run && m_word[2*SW-1-c_bit];
            check("bclk", {31'd0, bus.bclk}, {31'd0, e_bclk});
            check("lrclk", {31'd0, bus.lrclk}, {31'd0, e_lr});
            check("sdata", {31'd0, bus.sdata}, {31'd0, e_sd});
            check("sample_req", {31'd0, bus.sample_req}, {31'd0, m_req});
            check("underrun", {31'd0, bus.underrun}, {31'd0, m_und});
            check("overrun", {31'd0, bus.overrun}, {31'd0, m_ovr});
        end
    end

    // Starting right after a load edge, sample each bit slot and return the frame and lrclk patterns.
    task automatic capture(output logic [31:0] w, output logic [31:0] lr);
        w = '0; lr = '0;
        for (int k = 0; k < 2 * SW; k++) begin
            w  = {w[30:0], bus.sdata};
            lr = {lr[30:0], bus.lrclk};
            repeat (2 * B) tick();
        end
    endtask

    task automatic send(input logic [SW-1:0] s);
        bus.in_ready = 1'b1; bus.sample_in = s;
        tick();
        bus.in_ready = 1'b0;
    endtask

    task automatic wait_load();
        bit ok = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (bus.sample_req || bus.underrun) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("wait_load", {31'd0, ok}, 32'd1);
    endtask

    logic [31:0] w, lr;
    int          hi_cnt;

    initial begin
        reset = 1'b0; bus.enable = 1'b0; bus.in_ready = 1'b0; bus.sample_in = '0;
        tick();
        chk_en = 1'b1;
        // Reset with in_ready toggling.
        for (int i = 0; i < 3; i++) begin
            bus.in_ready = (i % 2 == 0); bus.sample_in = 16'h7E7E;
            tick();
        end
        bus.in_ready = 1'b0;
        check("reset_outs", {26'd0, bus.bclk, bus.lrclk, bus.sdata, bus.sample_req, bus.underrun, bus.overrun}, 32'd0);

        // Single frame of A5C3, load one edge after in_ready.
        reset = 1'b1; bus.enable = 1'b1;
        send(16'hA5C3);
        check("no_load_yet", {31'd0, bus.sample_req}, 32'd0);
        tick();
        check("first_load_req", {31'd0, bus.sample_req}, 32'd1);
        capture(w, lr);
        check("frame_a5c3", w, 32'hA5C3A5C3);
        check("lrclk_pattern", lr, 32'h0000FFFF);
        check("frame_len_underrun", {30'd0, bus.underrun, bus.sample_req}, 32'd2);
        capture(w, lr);
        check("underrun_repeat", w, 32'hA5C3A5C3);

        // Overrun mid-frame.
        repeat (50) tick();
        send(16'h0001);
        repeat (20) tick();
        send(16'h8000);
        check("overrun_pulse", {31'd0, bus.overrun}, 32'd1);
        wait_load();
        check("load_after_ovr", {31'd0, bus.sample_req}, 32'd1);
        capture(w, lr);
        check("frame_8000", w, 32'h80008000);

        // in_ready exactly on the load edge.
        send(16'h1234);
        repeat (FRAME - 2) tick();
        send(16'h5678);
        check("coinc_req", {31'd0, bus.sample_req}, 32'd1);
        check("coinc_no_ovr", {31'd0, bus.overrun}, 32'd0);
        capture(w, lr);
        check("coinc_old", w, 32'h12341234);
        check("coinc_next_req", {31'd0, bus.sample_req}, 32'd1);
        capture(w, lr);
        check("coinc_new", w, 32'h56785678);

        // enable dropped at bit 5: frame completes, then idle, then restart.
        send(16'h4321);
        repeat (40) tick();
        bus.enable = 1'b0;
        repeat (FRAME - 41) tick();
        check("idle_outs", {27'd0, bus.bclk, bus.lrclk, bus.sdata, bus.sample_req, bus.underrun}, 32'd0);
        hi_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.bclk || bus.sdata) hi_cnt++;
        end
        check("idle_quiet", hi_cnt, 32'd0);
        bus.enable = 1'b1;
        tick();
        check("restart_req", {31'd0, bus.sample_req}, 32'd1);
        capture(w, lr);
        check("restart_frame", w, 32'h43214321);

        // Reset at bit 20, then negative full-scale sample.
        repeat (20 * 2 * B) tick();
        reset = 1'b0;
        tick();
        check("midreset_outs", {26'd0, bus.bclk, bus.lrclk, bus.sdata, bus.sample_req, bus.underrun, bus.overrun}, 32'd0);
        reset = 1'b1;
        repeat (30) tick();
        check("no_frame_after_reset", {30'd0, bus.bclk, bus.sdata}, 32'd0);
        send(16'hFFFF);
        tick();
        check("ffff_req", {31'd0, bus.sample_req}, 32'd1);
        capture(w, lr);
        check("frame_ffff", w, 32'hFFFFFFFF);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 1999) != 0);
            if ($urandom_range(0, 299) == 0) bus.enable = ~bus.enable;
            bus.in_ready  = ($urandom_range(0, 180) == 0);
            bus.sample_in = SW'($urandom);
            tick();
        end
        reset = 1'b1; bus.in_ready = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
